// File: rtl/fifo_wrt_arbiter_if.sv
// Write-port bundle between requesters, arbiter and async FIFO.
// master: requesters + FIFO side; slave: the arbiter.
interface fifo_wrt_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    grant;
  logic               full;
  logic               wrt_en;
  logic [DW-1:0]      wrt_data;

  modport master (
    output req,
    output req_data,
    output full,
    input  ack,
    input  grant,
    input  wrt_en,
    input  wrt_data
  );

  modport slave (
    input  req,
    input  req_data,
    input  full,
    output ack,
    output grant,
    output wrt_en,
    output wrt_data
  );
endinterface

// File: rtl/fifo_wrt_arbiter.sv
// Round-robin burst arbiter for the async FIFO write port.
// Ports: wrt_clk, wrt_rst_n, bus (slave), busy, beat_cnt.
module fifo_wrt_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                wrt_clk,
  input  logic                wrt_rst_n,
  fifo_wrt_arbiter_if.slave   bus,
  output logic                busy,
  output logic [15:0]         beat_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] grant_d;
  logic [PW-1:0]   rr_q;
  logic [PW-1:0]   rr_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [15:0]     beat_q;
  logic [15:0]     beat_d;

  logic [NREQ-1:0] ack;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   nxt;
  logic [PW-1:0]   from;
  logic            win_ok;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] win_oh;
  logic            g_ack;
  logic            g_req;
  logic            rel;
  logic [DW-1:0]   data_mux;

  assign ack   = grant_q & bus.req & {NREQ{~bus.full}};
  assign g_ack = |ack;
  assign g_req = |(grant_q & bus.req);

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) gidx = PW'(i);
    end
  end

  assign nxt = (gidx == IDX_LAST) ? '0 : gidx + PW'(1);

  // Mid-burst the search starts after the holder; idle uses rr_q.
  assign from = (state_q == BURST) ? nxt : rr_q;

  always_comb begin
    int idx;
    idx     = 0;
    win_ok  = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(from) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_ok && bus.req[idx]) begin
        win_ok  = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  assign win_oh = win_ok ? (ONE << win_idx) : '0;

  always_comb begin
    data_mux = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) data_mux = bus.req_data[i*DW +: DW];
    end
  end

  // Release on the last beat, or as soon as the holder withdraws.
  assign rel = (g_ack && (cnt_q == CNT_LAST)) || !g_req;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_d = win_oh;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (g_ack) begin
          cnt_d  = cnt_q + CW'(1);
          beat_d = beat_q + 16'd1;
        end
        if (rel) begin
          rr_d  = nxt;
          cnt_d = '0;
          if (win_ok) begin
            grant_d = win_oh;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wrt_clk or negedge wrt_rst_n) begin
    if (!wrt_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.ack      = ack;
  assign bus.grant    = grant_q;
  assign bus.wrt_en   = g_ack;
  assign bus.wrt_data = data_mux;
  assign busy         = (state_q == BURST);
  assign beat_cnt     = beat_q;

endmodule

// File: tb/tb_fifo_wrt_arbiter.sv
// Directed bench for fifo_wrt_arbiter.
// Drives after posedge, samples on negedge.
module tb_fifo_wrt_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] beat_cnt;
  int          tests = 0;
  int          failed = 0;

  localparam logic [31:0] DATA = 32'hD3C2B1A0;

  fifo_wrt_arbiter_if #(.NREQ(4), .DW(8)) bus ();

  fifo_wrt_arbiter #(
    .NREQ(4),
    .DW(8),
    .MAX_BURST(4)
  ) dut (
    .wrt_clk  (clk),
    .wrt_rst_n(rst_n),
    .bus      (bus),
    .busy     (busy),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_data = DATA;
    bus.full     = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.req      = 4'b1111;
    bus.req_data = DATA;
    bus.full     = 1'b0;
    nxt();
    @(negedge clk);
    tests++;
    if (bus.grant !== 4'b0 || bus.ack !== 4'b0) begin
      failed++;
      $display("FAIL rst_grant_ack got %b/%b exp 0000/0000",
               bus.grant, bus.ack);
    end
    tests++;
    if (bus.wrt_en !== 1'b0 || bus.wrt_data !== 8'h00) begin
      failed++;
      $display("FAIL rst_wr got %b/%h exp 0/00",
               bus.wrt_en, bus.wrt_data);
    end
    tests++;
    if (busy !== 1'b0 || beat_cnt !== 16'd0) begin
      failed++;
      $display("FAIL rst_busy_cnt got %b/%0d exp 0/0",
               busy, beat_cnt);
    end
    nxt();
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0001;
    @(negedge clk);
    tests++;
    if (bus.grant !== 4'b0000 || bus.ack !== 4'b0000) begin
      failed++;
      $display("FAIL t1_c0 got %b/%b exp 0000/0000",
               bus.grant, bus.ack);
    end
    nxt();
    for (int b = 0; b < 6; b++) begin
      bus.req_data[7:0] = 8'h50 + 8'(b);
      @(negedge clk);
      tests++;
      if (bus.grant !== 4'b0001 || bus.ack !== 4'b0001 ||
          bus.wrt_en !== 1'b1 ||
          bus.wrt_data !== 8'h50 + 8'(b)) begin
        failed++;
        $display("FAIL t1_beat%0d got %b/%b/%b/%h exp 0001/0001/1/%h",
                 b, bus.grant, bus.ack, bus.wrt_en,
                 bus.wrt_data, 8'h50 + 8'(b));
      end
      nxt();
    end
    bus.req = 4'b0000;
    tests++;
    if (beat_cnt !== 16'd6) begin
      failed++;
      $display("FAIL t1_beat_cnt got %0d exp 6", beat_cnt);
    end
    nxt();
    @(negedge clk);
    tests++;
    if (bus.grant !== 4'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL t1_idle got %b/%b exp 0000/0", bus.grant, busy);
    end
    nxt();
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    do_reset();
    bus.req = 4'b1111;
    nxt();
    for (int c = 0; c < 20; c++) begin
      eg = 4'b0001 << ((c / 4) % 4);
      @(negedge clk);
      tests++;
      if (bus.grant !== eg || bus.ack !== eg ||
          $countones(bus.ack) != 1) begin
        failed++;
        $display("FAIL t2_c%0d got %b/%b exp %b/%b",
                 c, bus.grant, bus.ack, eg, eg);
      end
      tests++;
      if (bus.wrt_data !== 8'hA0 + 8'h11 * 8'((c / 4) % 4)) begin
        failed++;
        $display("FAIL t2_data%0d got %h exp %h", c, bus.wrt_data,
                 8'hA0 + 8'h11 * 8'((c / 4) % 4));
      end
      nxt();
    end
    bus.req = 4'b0000;
    tests++;
    if (beat_cnt !== 16'd20) begin
      failed++;
      $display("FAIL t2_beat_cnt got %0d exp 20", beat_cnt);
    end
    nxt();
  endtask

  task automatic test_full_stall();
    do_reset();
    bus.req = 4'b0010;
    nxt();
    for (int c = 0; c < 7; c++) begin
      bus.full = (c >= 2 && c < 5);
      if (c == 6) bus.req = 4'b1010;
      @(negedge clk);
      tests++;
      if (bus.full) begin
        if (bus.ack !== 4'b0 || bus.wrt_en !== 1'b0 ||
            bus.grant !== 4'b0010) begin
          failed++;
          $display("FAIL t3_full%0d got %b/%b/%b exp 0000/0/0010",
                   c, bus.ack, bus.wrt_en, bus.grant);
        end
      end else begin
        if (bus.ack !== 4'b0010 || bus.wrt_en !== 1'b1 ||
            bus.wrt_data !== 8'hB1) begin
          failed++;
          $display("FAIL t3_beat%0d got %b/%b/%h exp 0010/1/b1",
                   c, bus.ack, bus.wrt_en, bus.wrt_data);
        end
      end
      nxt();
    end
    @(negedge clk);
    tests++;
    if (bus.grant !== 4'b1000 || beat_cnt !== 16'd4) begin
      failed++;
      $display("FAIL t3_release got %b/%0d exp 1000/4",
               bus.grant, beat_cnt);
    end
    nxt();
  endtask

  task automatic test_drop_req();
    do_reset();
    bus.req = 4'b1010;
    nxt();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++;
      if (bus.ack !== 4'b0010) begin
        failed++;
        $display("FAIL t4_beat%0d got %b exp 0010", c, bus.ack);
      end
      nxt();
    end
    bus.req = 4'b1000;
    @(negedge clk);
    tests++;
    if (bus.grant !== 4'b0010 || bus.ack !== 4'b0000) begin
      failed++;
      $display("FAIL t4_drop got %b/%b exp 0010/0000",
               bus.grant, bus.ack);
    end
    nxt();
    @(negedge clk);
    tests++;
    if (bus.grant !== 4'b1000 || bus.ack !== 4'b1000 ||
        bus.wrt_data !== DATA[31:24]) begin
      failed++;
      $display("FAIL t4_handover got %b/%b/%h exp 1000/1000/%h",
               bus.grant, bus.ack, bus.wrt_data, DATA[31:24]);
    end
    nxt();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 4'b0100;
    nxt();
    nxt();
    @(negedge clk);
    tests++;
    if (bus.ack !== 4'b0100 || beat_cnt !== 16'd1 || busy !== 1'b1) begin
      failed++;
      $display("FAIL t5_pre got %b/%0d/%b exp 0100/1/1",
               bus.ack, beat_cnt, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.grant !== 4'b0 || bus.wrt_en !== 1'b0 ||
        busy !== 1'b0 || beat_cnt !== 16'd0) begin
      failed++;
      $display("FAIL t5_rst got %b/%b/%b/%0d exp 0000/0/0/0",
               bus.grant, bus.wrt_en, busy, beat_cnt);
    end
    bus.req = 4'b1111;
    nxt();
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.grant !== 4'b0000) begin
      failed++;
      $display("FAIL t5_idle got %b exp 0000", bus.grant);
    end
    nxt();
    @(negedge clk);
    tests++;
    if (bus.grant !== 4'b0001) begin
      failed++;
      $display("FAIL t5_first got %b exp 0001", bus.grant);
    end
    nxt();
  endtask

  task automatic test_wrap();
    int acks = 0;
    int bad = 0;
    int c = 0;
    do_reset();
    bus.req = 4'b0001;
    while (acks < 65537 && c < 70000) begin
      bus.full = (c % 32 == 5);
      @(negedge clk);
      if (bus.full && (bus.ack !== 4'b0 || bus.wrt_en !== 1'b0)) bad++;
      if (bus.ack[0] === 1'b1) acks++;
      nxt();
      c++;
    end
    bus.full = 1'b0;
    tests++;
    if (acks != 65537) begin
      failed++;
      $display("FAIL t6_budget got %0d acks exp 65537", acks);
    end
    tests++;
    if (beat_cnt !== 16'd1) begin
      failed++;
      $display("FAIL t6_wrap got %0d exp 1", beat_cnt);
    end
    tests++;
    if (bad != 0) begin
      failed++;
      $display("FAIL t6_full_ack got %0d exp 0", bad);
    end
    bus.req = 4'b0000;
    nxt();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_drop_req();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
